// File: rtl/clock_pkg.sv
// Shared time-of-day widths, constants and the alarm sequencing state type.
package clock_pkg;

    localparam int MIN_W            = 7;
    localparam int HR_W             = 6;
    localparam int MINUTES_PER_HOUR = 60;
    localparam int HOURS_PER_DAY    = 24;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZED  = 2'd3
    } alarm_state_t;

endpackage

// File: rtl/time_add_min.sv
// Combinational time-of-day adder: hh:mm plus a minute offset (< 60),
// wrapping minutes into the hour and hours past midnight.
module time_add_min #(
    parameter int MIN_W = clock_pkg::MIN_W,
    parameter int HR_W  = clock_pkg::HR_W
) (
    input  logic [MIN_W-1:0] i_minutes,
    input  logic [HR_W-1:0]  i_hours,
    input  logic [MIN_W-1:0] i_add_minutes,
    output logic [MIN_W-1:0] o_minutes,
    output logic [HR_W-1:0]  o_hours
);

    logic [MIN_W-1:0] w_sum;

    // Add minutes; carry one hour when the sum leaves the current hour.
    always_comb begin
        w_sum     = i_minutes + i_add_minutes;
        o_minutes = w_sum;
        o_hours   = i_hours;
        if (w_sum >= MIN_W'(clock_pkg::MINUTES_PER_HOUR)) begin
            o_minutes = w_sum - MIN_W'(clock_pkg::MINUTES_PER_HOUR);
            if (i_hours == HR_W'(clock_pkg::HOURS_PER_DAY - 1)) begin
                o_hours = '0;
            end else begin
                o_hours = i_hours + HR_W'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencing controller. Owns the comparator's configuration port,
// turns comparator matches into ringing, and handles timeout, snooze
// (reprogram to now + SNOOZE_MIN), bounded snooze count and restore of the
// user's alarm time on stop/disable.
//
// Handshake: set_alarm is a one-cycle registered strobe; set_minutes and
// set_hours are valid in that cycle and hold their value afterwards. There is
// no back-pressure: the comparator must accept the strobe in the cycle it is
// presented. All button inputs are single-cycle pulses sampled every edge.
module alarm_ring_ctrl #(
    parameter int MIN_W      = 7,
    parameter int HR_W       = 6,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic [MIN_W-1:0] curr_minutes,
    input  logic [HR_W-1:0]  curr_hours,
    input  logic             alarm_enable,
    input  logic             user_set,
    input  logic [MIN_W-1:0] user_minutes,
    input  logic [HR_W-1:0]  user_hours,
    input  logic             snooze_btn,
    input  logic             stop_btn,
    input  logic             alarm_trigger,
    output logic             set_alarm,
    output logic [MIN_W-1:0] set_minutes,
    output logic [HR_W-1:0]  set_hours,
    output logic             buzzer,
    output logic             snoozed,
    output logic [3:0]       snooze_cnt,
    output logic [1:0]       o_state
);

    clock_pkg::alarm_state_t r_state;
    logic             r_trig_q;
    logic [MIN_W-1:0] r_user_min;
    logic [HR_W-1:0]  r_user_hr;
    logic [7:0]       r_ring_cnt;
    logic [3:0]       r_snooze_cnt;
    logic             r_set_alarm;
    logic [MIN_W-1:0] r_set_min;
    logic [HR_W-1:0]  r_set_hr;
    logic             r_buzzer;
    logic             r_snoozed;

    logic [MIN_W-1:0] w_snz_min;
    logic [HR_W-1:0]  w_snz_hr;
    logic             w_trig_rise;
    logic             w_timeout;
    logic             w_ring_end;
    logic             w_can_snooze;
    logic             w_stop;
    logic             w_snooze;

    time_add_min #(.MIN_W(MIN_W), .HR_W(HR_W)) u_snooze_add (
        .i_minutes     (curr_minutes),
        .i_hours       (curr_hours),
        .i_add_minutes (MIN_W'(SNOOZE_MIN)),
        .o_minutes     (w_snz_min),
        .o_hours       (w_snz_hr)
    );

    // Event decode: a stop (explicit, or a ring end with no snoozes left)
    // always beats a snooze.
    always_comb begin
        w_trig_rise  = alarm_trigger & ~r_trig_q;
        w_timeout    = tick_1hz && (r_ring_cnt == 8'(RING_SEC - 1));
        w_ring_end   = snooze_btn | w_timeout;
        w_can_snooze = (r_snooze_cnt < 4'(MAX_SNOOZE));
        w_stop       = ((r_state == clock_pkg::RINGING) &&
                        (stop_btn || (w_ring_end && !w_can_snooze))) ||
                       ((r_state == clock_pkg::SNOOZED) && stop_btn);
        w_snooze     = (r_state == clock_pkg::RINGING) && !stop_btn &&
                       w_ring_end && w_can_snooze;
    end

    // Sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= clock_pkg::DISARMED;
            r_trig_q     <= 1'b0;
            r_user_min   <= '0;
            r_user_hr    <= '0;
            r_ring_cnt   <= '0;
            r_snooze_cnt <= '0;
            r_set_alarm  <= 1'b0;
            r_set_min    <= '0;
            r_set_hr     <= '0;
            r_buzzer     <= 1'b0;
            r_snoozed    <= 1'b0;
        end else begin
            r_trig_q    <= alarm_trigger;
            r_set_alarm <= 1'b0;
            if (!alarm_enable && (r_state == clock_pkg::RINGING ||
                                  r_state == clock_pkg::SNOOZED)) begin
                r_state     <= clock_pkg::DISARMED;
                r_buzzer    <= 1'b0;
                r_snoozed   <= 1'b0;
                r_set_alarm <= 1'b1;
                r_set_min   <= r_user_min;
                r_set_hr    <= r_user_hr;
            end else if (user_set) begin
                r_user_min   <= user_minutes;
                r_user_hr    <= user_hours;
                r_set_alarm  <= 1'b1;
                r_set_min    <= user_minutes;
                r_set_hr     <= user_hours;
                r_snooze_cnt <= '0;
                r_buzzer     <= 1'b0;
                r_snoozed    <= 1'b0;
                r_state      <= alarm_enable ? clock_pkg::ARMED : clock_pkg::DISARMED;
            end else if (!alarm_enable) begin
                r_state <= clock_pkg::DISARMED;
            end else if (w_stop) begin
                r_state      <= clock_pkg::ARMED;
                r_snooze_cnt <= '0;
                r_buzzer     <= 1'b0;
                r_snoozed    <= 1'b0;
                r_set_alarm  <= 1'b1;
                r_set_min    <= r_user_min;
                r_set_hr     <= r_user_hr;
            end else if (w_snooze) begin
                r_state      <= clock_pkg::SNOOZED;
                r_snooze_cnt <= r_snooze_cnt + 4'd1;
                r_buzzer     <= 1'b0;
                r_snoozed    <= 1'b1;
                r_set_alarm  <= 1'b1;
                r_set_min    <= w_snz_min;
                r_set_hr     <= w_snz_hr;
            end else begin
                case (r_state)
                    clock_pkg::DISARMED: r_state <= clock_pkg::ARMED;
                    clock_pkg::ARMED, clock_pkg::SNOOZED: begin
                        if (w_trig_rise) begin
                            r_state    <= clock_pkg::RINGING;
                            r_ring_cnt <= '0;
                            r_buzzer   <= 1'b1;
                            r_snoozed  <= 1'b0;
                        end
                    end
                    clock_pkg::RINGING: begin
                        if (tick_1hz) begin
                            r_ring_cnt <= r_ring_cnt + 8'd1;
                        end
                    end
                    default: r_state <= clock_pkg::DISARMED;
                endcase
            end
        end
    end

    assign set_alarm   = r_set_alarm;
    assign set_minutes = r_set_min;
    assign set_hours   = r_set_hr;
    assign buzzer      = r_buzzer;
    assign snoozed     = r_snoozed;
    assign snooze_cnt  = r_snooze_cnt;
    assign o_state     = r_state;

endmodule
